// File: rtl/uop_sequencer.sv
// ---------------------------------------------------------------------------
// uop_sequencer: issues a decoded micro-op group to execute one per cycle.
// Optional same-cycle bypass of 1-uop groups: UOP_SEQ_BYPASS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uop_sequencer #(
  parameter int MAX_UOPS = 4,
  parameter int UOP_W    = 64,
  parameter int CNT_W    = $clog2(MAX_UOPS + 1),
  parameter int IDX_W    = $clog2(MAX_UOPS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      flush,
  input  logic                      dec_valid,
  input  logic [CNT_W-1:0]          dec_num_uops,
  input  logic [MAX_UOPS*UOP_W-1:0] dec_uops,
  output logic                      dec_ready,
  output logic                      uop_valid,
  output logic [UOP_W-1:0]          uop_out,
  output logic [IDX_W-1:0]          uop_idx,
  output logic                      uop_last,
  input  logic                      ex_ready,
  output logic                      err_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_UOPS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             err_q, err_d;
  logic [UOP_W-1:0] slot_q [MAX_UOPS];
  logic             load;

  logic             over;
  logic [CNT_W-1:0] n_in;
  logic             buf_last;
  logic             bypass;
  logic             accept;

  assign over     = dec_num_uops > MAX_CNT;
  assign n_in     = over ? MAX_CNT : dec_num_uops;
  assign buf_last = (CNT_W'(idx_q) == (n_q - CNT_W'(1)));

`ifdef UOP_SEQ_BYPASS_EN
  // A lone micro-op offered while idle is shown to execute in the offer cycle.
  assign bypass = (state_q == IDLE) && dec_valid && !flush && !RST && (n_in == CNT_W'(1));
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    uop_valid = 1'b0;
    uop_out   = '0;
    uop_idx   = '0;
    uop_last  = 1'b0;
    if (state_q == ISSUE) begin
      uop_valid = 1'b1;
      uop_out   = slot_q[idx_q];
      uop_idx   = idx_q;
      uop_last  = buf_last;
    end else if (bypass) begin
      uop_valid = 1'b1;
      uop_out   = dec_uops[UOP_W-1:0];
      uop_last  = 1'b1;
    end
  end

  // Accepting on the last issue lets back-to-back groups run without a bubble.
  assign dec_ready = !RST && !flush &&
                     ((state_q == IDLE) || (uop_valid && uop_last && ex_ready));
  assign accept    = dec_valid && dec_ready;
  assign err_count = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    err_d   = 1'b0;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (accept) begin
      err_d = over;
      idx_d = '0;
      n_d   = n_in;
      if ((n_in == '0) || (bypass && ex_ready)) begin
        state_d = IDLE;
      end else begin
        state_d = ISSUE;
        load    = 1'b1;
      end
    end else if ((state_q == ISSUE) && ex_ready) begin
      if (buf_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      for (int k = 0; k < MAX_UOPS; k++) begin
        slot_q[k] <= dec_uops[k*UOP_W +: UOP_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uop_sequencer: scoreboard bench for uop_sequencer (MAX_UOPS=4, UOP_W=64).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uop_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         flush;
  logic         dec_valid;
  logic [2:0]   dec_num_uops;
  logic [255:0] dec_uops;
  logic         dec_ready;
  logic         uop_valid;
  logic [63:0]  uop_out;
  logic [1:0]   uop_idx;
  logic         uop_last;
  logic         ex_ready;
  logic         err_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  uop_sequencer #(.MAX_UOPS(4), .UOP_W(64)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_num_uops (dec_num_uops),
    .dec_uops     (dec_uops),
    .dec_ready    (dec_ready),
    .uop_valid    (uop_valid),
    .uop_out      (uop_out),
    .uop_idx      (uop_idx),
    .uop_last     (uop_last),
    .ex_ready     (ex_ready),
    .err_count    (err_count)
  );

  always #5 CLK = ~CLK;

  // Every micro-op consumed by execute is checked against the scoreboard.
  always @(negedge CLK) begin
    if (!RST && uop_valid && ex_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected got uop_out=%h idx=%0d, required no issue", uop_out, uop_idx);
      end else begin
        e = sb.pop_front();
        if (uop_out !== e.data || uop_idx !== e.idx || uop_last !== e.last) begin
          failures++;
          $display("FAIL issue_data got %h/%0d/%b required %h/%0d/%b",
                   uop_out, uop_idx, uop_last, e.data, e.idx, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [5:0] obs();
    return {uop_valid, uop_idx, uop_last, dec_ready, err_count};
  endfunction

  task automatic push_exp(input int n);
    int m = (n > 4) ? 4 : n;
    for (int k = 0; k < m; k++)
      sb.push_back('{data: dec_uops[k*64 +: 64], idx: 2'(k), last: (k == m - 1)});
  endtask

  task automatic offer(input int n, input bit push);
    logic [255:0] u;
    for (int k = 0; k < 4; k++) u[k*64 +: 64] = {$urandom, $urandom};
    dec_uops     = u;
    dec_num_uops = 3'(n);
    dec_valid    = 1'b1;
    if (push) push_exp(n);
  endtask

  task automatic test_reset;
    RST = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_num_uops = '0;
    dec_uops = '0; ex_ready = 1'b0;
    tick; tick; #1;
    checks++;
    if (dec_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_in_rst got %b required 0", dec_ready);
    end
    RST = 1'b0;
    tick; #1;
    checks++;
    if (obs() !== 6'b0_00_0_1_0 || uop_out !== 64'd0) begin
      failures++; $display("FAIL reset_state got %b out=%h required 000010 out=0", obs(), uop_out);
    end
    tick;
  endtask

  task automatic test_basic;
    logic [5:0] tbl [5] = '{6'b0_00_0_1_0, 6'b1_00_0_0_0, 6'b1_01_0_0_0,
                            6'b1_10_1_1_0, 6'b0_00_0_1_0};
    ex_ready = 1'b1;
    offer(3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) dec_valid = 1'b0;
      #1;
      checks++;
      if (obs() !== tbl[c]) begin
        failures++; $display("FAIL basic c=%0d got %b required %b", c, obs(), tbl[c]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] tbl [6] = '{6'b0_00_0_1_0, 6'b1_00_0_0_0, 6'b1_01_1_1_0,
                            6'b1_00_0_0_0, 6'b1_01_1_1_0, 6'b0_00_0_1_0};
    ex_ready = 1'b1;
    offer(2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) offer(2, 1'b1);
      if (c == 3) dec_valid = 1'b0;
      #1;
      checks++;
      if (obs() !== tbl[c]) begin
        failures++; $display("FAIL back_to_back c=%0d got %b required %b", c, obs(), tbl[c]);
      end
      tick;
    end
  endtask

  task automatic test_stall;
    logic [5:0] tbl [9] = '{6'b0_00_0_1_0, 6'b1_00_0_0_0, 6'b1_01_0_0_0,
                            6'b1_01_0_0_0, 6'b1_01_0_0_0, 6'b1_01_0_0_0,
                            6'b1_10_0_0_0, 6'b1_11_1_1_0, 6'b0_00_0_1_0};
    logic [63:0] slot1;
    ex_ready = 1'b1;
    offer(4, 1'b1);
    slot1 = dec_uops[127:64];
    for (int c = 0; c < 9; c++) begin
      if (c == 1) dec_valid = 1'b0;
      if (c == 2) ex_ready = 1'b0;
      if (c == 5) ex_ready = 1'b1;
      #1;
      checks++;
      if (obs() !== tbl[c]) begin
        failures++; $display("FAIL stall c=%0d got %b required %b", c, obs(), tbl[c]);
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (uop_out !== slot1) begin
          failures++; $display("FAIL stall_hold c=%0d got %h required %h", c, uop_out, slot1);
        end
      end
      tick;
    end
  endtask

  task automatic test_flush;
    logic [5:0] tbl [7] = '{6'b0_00_0_1_0, 6'b1_00_0_0_0, 6'b1_01_0_0_0,
                            6'b0_00_0_1_0, 6'b1_00_0_0_0, 6'b1_01_1_1_0,
                            6'b0_00_0_1_0};
    ex_ready = 1'b1;
    offer(4, 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c == 1) dec_valid = 1'b0;
      if (c == 2) begin
        flush = 1'b1;
        offer(2, 1'b0);
      end
      if (c == 3) begin
        flush = 1'b0;
        sb.delete();
        push_exp(2);
      end
      if (c == 4) dec_valid = 1'b0;
      #1;
      checks++;
      if (obs() !== tbl[c]) begin
        failures++; $display("FAIL flush c=%0d got %b required %b", c, obs(), tbl[c]);
      end
      tick;
    end
  endtask

  task automatic test_count_edges;
    logic [5:0] tbl [7] = '{6'b0_00_0_1_0, 6'b0_00_0_1_0, 6'b1_00_0_0_1,
                            6'b1_01_0_0_0, 6'b1_10_0_0_0, 6'b1_11_1_1_0,
                            6'b0_00_0_1_0};
    ex_ready = 1'b1;
    offer(0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      if (c == 1) offer(6, 1'b1);
      if (c == 2) dec_valid = 1'b0;
      #1;
      checks++;
      if (obs() !== tbl[c]) begin
        failures++; $display("FAIL count_edges c=%0d got %b required %b", c, obs(), tbl[c]);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_group;
    ex_ready = 1'b1;
    offer(4, 1'b1);
    tick;
    dec_valid = 1'b0;
    tick;
    RST = 1'b1;
    #1;
    checks++;
    if (obs() !== 6'b1_01_0_0_0) begin
      failures++; $display("FAIL rst_mid_in_rst got %b required 101000", obs());
    end
    tick;
    RST = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (obs() !== 6'b0_00_0_1_0 || uop_out !== 64'd0) begin
      failures++; $display("FAIL rst_mid_after got %b out=%h required 000010 out=0", obs(), uop_out);
    end
    tick;
  endtask

  task automatic test_single;
    logic [63:0] d;
    ex_ready = 1'b1;
    offer(1, 1'b1);
    d = dec_uops[63:0];
`ifdef UOP_SEQ_BYPASS_EN
    #1;
    checks++;
    if (obs() !== 6'b1_00_1_1_0 || uop_out !== d) begin
      failures++; $display("FAIL bypass_same_cycle got %b out=%h required 100110 out=%h", obs(), uop_out, d);
    end
    tick;
    dec_valid = 1'b0;
    #1;
    checks++;
    if (obs() !== 6'b0_00_0_1_0) begin
      failures++; $display("FAIL bypass_stays_idle got %b required 000010", obs());
    end
    tick;
`else
    #1;
    checks++;
    if (obs() !== 6'b0_00_0_1_0) begin
      failures++; $display("FAIL single_accept got %b required 000010", obs());
    end
    tick;
    dec_valid = 1'b0;
    #1;
    checks++;
    if (obs() !== 6'b1_00_1_1_0 || uop_out !== d) begin
      failures++; $display("FAIL single_issue got %b out=%h required 100110 out=%h", obs(), uop_out, d);
    end
    tick;
    #1;
    checks++;
    if (obs() !== 6'b0_00_0_1_0) begin
      failures++; $display("FAIL single_done got %b required 000010", obs());
    end
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_stall;
    test_flush;
    test_count_edges;
    test_reset_mid_group;
    test_single;
    tick;
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uop_sequencer.md
# uop_sequencer

Issue controller between the stage-4 decode stage and the execute stage. It accepts one decoded macro-instruction as a group of 1..MAX_UOPS micro-ops with a count. It issues those micro-ops to execute one per cycle under a valid/ready handshake. It back-pressures decode while a group is in flight and discards the in-flight group on a pipeline flush.

## Interface
Parameters:
- MAX_UOPS, 4: maximum micro-ops per macro-instruction; power of two, ≥2.
- UOP_W, 64: width of one packed uop_t.
- CNT_W, $clog2(MAX_UOPS+1): width of the count field.
- IDX_W, $clog2(MAX_UOPS): width of the micro-op index.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: reset, synchronous, active-high.
- flush, in, 1: discard the in-flight group.
- dec_valid, in, 1: decode is offering a group.
- dec_num_uops, in, CNT_W: micro-op count of the offered group.
- dec_uops, in, MAX_UOPS*UOP_W: micro-ops; slot k is bits [k*UOP_W +: UOP_W].
- dec_ready, out, 1: the sequencer accepts the group this cycle.
- uop_valid, out, 1: uop_out is valid.
- uop_out, out, UOP_W: current micro-op.
- uop_idx, out, IDX_W: index of uop_out within its group.
- uop_last, out, 1: uop_out is the final micro-op of its group.
- ex_ready, in, 1: execute consumes uop_out this cycle.
- err_count, out, 1: one-cycle pulse when an accepted count exceeded MAX_UOPS.

## Operation
- Accept: the group is accepted when dec_valid && dec_ready. The sequencer latches dec_uops and the effective count n = min(dec_num_uops, MAX_UOPS) into one group buffer.
- Issue: a micro-op is issued when uop_valid && ex_ready.
- States:
  - IDLE: buffer empty, uop_valid=0.
  - ISSUE: buffer holds n≥1 micro-ops; uop_out = slot[idx].
- Transitions:
  - IDLE→ISSUE on accept with n≥1. idx←0.
  - IDLE→IDLE on accept with n=0. No micro-op is emitted; this is a NOP group.
  - In ISSUE, a non-last issue does idx←idx+1.
  - In ISSUE, a last issue (idx==n-1) goes →IDLE, or reloads and stays in ISSUE if a new group is accepted that same cycle.
- dec_ready = !RST && !flush && (state==IDLE || (uop_valid && uop_last && ex_ready)).
- uop_last = uop_valid && (idx == n-1).
- If dec_num_uops > MAX_UOPS, the count is clamped and err_count pulses in the cycle after the accept.
- flush:
  - Has priority over everything else; next state is IDLE and idx←0.
  - A dec_valid in the same cycle is not accepted.
  - An issue in the same cycle still counts as consumed by execute. Execute is responsible for squashing it.
- ex_ready low: uop_out, uop_idx and uop_last hold stable.
- The count is evaluated modulo nothing. Clamping applies before latching, and idx never exceeds n-1.

## Timing
- Reset values (cycle after RST high): state IDLE, uop_valid 0, uop_out 0, uop_idx 0, uop_last 0, err_count 0. While RST is high, dec_ready is 0.
- uop_out is 0 whenever uop_valid is 0.
- Latency: accept at cycle N puts micro-op 0 on the outputs at N+1, when the bypass is compiled out.
- Throughput: one micro-op per cycle while ex_ready=1. Back-to-back groups issue with no bubble, because the accept overlaps the last issue.
- Flush asserted at cycle F gives uop_valid=0 at F+1. dec_ready is 1 at F+1 unless RST is high.
- RST mid-group drops the buffer exactly as flush does.

## Configuration
- UOP_SEQ_BYPASS_EN defined: when in IDLE with dec_valid && !flush and n==1, dec_uops slot 0 is driven combinationally onto uop_out in the same cycle.
  - In that case uop_valid=1, uop_last=1 and uop_idx=0 in that cycle.
  - If ex_ready is also 1, the group is accepted and consumed without entering ISSUE.
  - Otherwise it is latched and re-presented from the buffer at N+1.
- UOP_SEQ_BYPASS_EN undefined: all outputs are registered, with fixed one-cycle accept-to-issue latency.

## Test plan
- 3-uop group at cycle N, ex_ready=1 throughout → uop_idx 0,1,2 at N+1..N+3. uop_last=1 only at N+3. dec_ready=1 at N+3.
- Two 2-uop groups offered back-to-back → uop_valid high for 4 consecutive cycles, idx sequence 0,1,0,1, no bubble.
- 4-uop group, ex_ready=0 for 3 cycles at idx 1 → uop_out and idx hold at slot 1. Issue resumes at idx 2 after ex_ready rises.
- Flush at idx 1 of a 4-uop group with dec_valid=1 in the same cycle → next cycle uop_valid=0 and the new group is not accepted. It is accepted on the following cycle.
- num_uops=0 → no uop_valid and dec_ready stays 1. num_uops=6 with MAX_UOPS=4 → exactly 4 micro-ops issued and err_count pulses once.
- With UOP_SEQ_BYPASS_EN: 1-uop group in IDLE with ex_ready=1 → uop_valid=1 and uop_last=1 in the accept cycle, and state stays IDLE. Without the macro, the same stimulus gives uop_valid at the next cycle.
